// File: rtl/output_bram_reader.sv
// output_bram_reader: drains a ROWS x COLS Q2.14 matrix from BRAM port B onto a valid/ready stream.
// Define READER_ROW_MAX_EN to add a per-row signed running max (o_row_max / o_row_max_valid).
module output_bram_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int ROWS   = 32,
    parameter int COLS   = 32,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_bram_en,
    output logic [ADDR_W-1:0] o_bram_addr,
    input  logic [DATA_W-1:0] i_bram_dout,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last_col,
    output logic              o_last
`ifdef READER_ROW_MAX_EN
    ,
    output logic signed [DATA_W-1:0] o_row_max,
    output logic                     o_row_max_valid
`endif
);
    localparam int DEPTH = RD_LAT + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(2 * DEPTH + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS * COLS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_d;

    logic [ADDR_W-1:0] base, idx;
    logic [RD_LAT-1:0] pipe;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, inflight;
    logic [KW-1:0]     col;
    logic [RW-1:0]     row;
    logic              push, pop, start_ok, at_col_end;

    // A beat leaving this cycle frees its slot, so the credit check sustains one read per cycle.
    always_comb begin
        start_ok    = (state == IDLE) && i_start;
        inflight    = CW'($countones(pipe));
        push        = pipe[RD_LAT-1];
        o_valid     = (count != '0);
        pop         = o_valid && i_ready;
        o_bram_en   = (state == READ) && (inflight + count < CW'(DEPTH) + CW'(pop));
        o_bram_addr = base + idx;
        o_data      = mem[rd_ptr];
        at_col_end  = (col == KW'(COLS - 1));
        o_last_col  = o_valid && at_col_end;
        o_last      = o_last_col && (row == RW'(ROWS - 1));
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        state_d     = state;
        unique case (state)
            IDLE:    state_d = start_ok ? READ : IDLE;
            READ:    state_d = (o_bram_en && idx == LAST_IDX) ? DRAIN : READ;
            DRAIN:   state_d = (pop && o_last) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            base   <= '0;
            idx    <= '0;
            pipe   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            col    <= '0;
            row    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_d;
            pipe  <= RD_LAT'({pipe, o_bram_en});
            if (start_ok) begin
                base <= i_base_addr;
                idx  <= '0;
                col  <= '0;
                row  <= '0;
            end else if (o_bram_en) begin
                idx <= idx + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= i_bram_dout;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                col    <= at_col_end ? '0 : col + 1'b1;
                if (at_col_end) row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef READER_ROW_MAX_EN
    logic signed [DATA_W-1:0] run_max, cand;

    // The first beat of a row seeds the max regardless of the previous row's value.
    always_comb cand = (col == '0 || $signed(o_data) > run_max) ? o_data : run_max;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            run_max         <= '0;
            o_row_max       <= '0;
            o_row_max_valid <= 1'b0;
        end else begin
            o_row_max_valid <= pop && at_col_end;
            if (pop) run_max <= cand;
            if (pop && at_col_end) o_row_max <= cand;
        end
    end
`endif
endmodule
